// File: rtl/riscboy_lcd_spi_rx.sv
// LCD serial bus receiver: oversamples cs/dc/sck/mosi and deserialises words into a valid/ready FIFO.
// Optional px_count output enabled by defining RISCBOY_LCD_SPI_RX_PXCOUNT_EN.
module riscboy_lcd_spi_rx #(
  parameter int W_DATA     = 16,
  parameter int W_SHAMT    = $clog2(W_DATA + 1),
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lcd_cs,
  input  logic               lcd_dc,
  input  logic               lcd_sck,
  input  logic               lcd_mosi,
  input  logic [W_SHAMT-1:0] cfg_width,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [W_DATA-1:0]  out_data,
  output logic               out_dc,
  input  logic               clr_flags,
  output logic               overflow,
  output logic               frame_err,
  output logic               busy
`ifdef RISCBOY_LCD_SPI_RX_PXCOUNT_EN
  ,
  output logic [15:0]        px_count
`endif
);

  localparam int W_PTR = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          sync1_q, sync1_d, sync2_q;
  logic                sck_prev_q;
  logic [W_SHAMT-1:0]  bit_cnt_q, bit_cnt_d;
  logic [W_SHAMT-1:0]  width_q, width_d;
  logic [W_DATA-2:0]   shift_q, shift_d;
  logic [W_PTR-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d, frame_err_q, frame_err_d, busy_q, busy_d;
  logic [W_DATA:0]     mem_q [FIFO_DEPTH];

  logic                sync_cs, sync_dc, sync_sck, sync_mosi, rise;
  logic [W_SHAMT-1:0]  cfg_eff, cur_width, cnt_inc;
  logic [W_DATA-1:0]   shift_nxt, word_mask;
  logic                complete, frame_set, full, empty, pop, push, ovf_set;
  logic [W_DATA:0]     head;

  assign sync1_d   = {lcd_cs, lcd_dc, lcd_sck, lcd_mosi};
  assign sync_cs   = sync2_q[3];
  assign sync_dc   = sync2_q[2];
  assign sync_sck  = sync2_q[1];
  assign sync_mosi = sync2_q[0];
  assign rise      = sync_sck && !sck_prev_q && !sync_cs;

  // The width used for the current word is sampled on its first bit only.
  assign cfg_eff   = (cfg_width == '0 || cfg_width > W_SHAMT'(W_DATA)) ? W_SHAMT'(W_DATA) : cfg_width;
  assign cur_width = (bit_cnt_q == '0) ? cfg_eff : width_q;
  assign cnt_inc   = bit_cnt_q + W_SHAMT'(1);
  assign shift_nxt = {shift_q, sync_mosi};

  always_comb begin
    word_mask = '0;
    for (int i = 0; i < W_DATA; i++) word_mask[i] = (i < int'(cur_width));
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    width_d   = width_q;
    shift_d   = shift_q;
    complete  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE:  if (!sync_cs) state_d = ST_SHIFT;
      ST_SHIFT: if (sync_cs) begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        shift_d   = '0;
        frame_set = (bit_cnt_q != '0);
      end
      default:  state_d = ST_IDLE;
    endcase
    if (rise) begin
      if (bit_cnt_q == '0) width_d = cfg_eff;
      shift_d = shift_nxt[W_DATA-2:0];
      if (cnt_inc == cur_width) begin
        complete  = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = cnt_inc;
      end
    end
  end

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {(W_PTR-1){1'b0}}});
  assign pop      = !empty && out_rdy;
  assign push     = complete && (!full || pop);
  assign ovf_set  = complete && full && !pop;
  assign wr_ptr_d = wr_ptr_q + W_PTR'(push);
  assign rd_ptr_d = rd_ptr_q + W_PTR'(pop);

  assign overflow_d  = ovf_set   || (overflow_q  && !clr_flags);
  assign frame_err_d = frame_set || (frame_err_q && !clr_flags);
  assign busy_d      = !sync_cs || (bit_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 4'b1000;
      sync2_q     <= 4'b1000;
      sck_prev_q  <= 1'b0;
      bit_cnt_q   <= '0;
      width_q     <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync1_q;
      sck_prev_q  <= sync_sck;
      bit_cnt_q   <= bit_cnt_d;
      width_q     <= width_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      if (push) mem_q[wr_ptr_q[W_PTR-2:0]] <= {sync_dc, shift_nxt & word_mask};
    end
  end

  assign head      = mem_q[rd_ptr_q[W_PTR-2:0]];
  assign out_vld   = !empty;
  assign out_data  = out_vld ? head[W_DATA-1:0] : '0;
  assign out_dc    = out_vld ? head[W_DATA] : 1'b0;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

`ifdef RISCBOY_LCD_SPI_RX_PXCOUNT_EN
  logic [15:0] px_q, px_d;

  always_comb begin
    px_d = px_q;
    if (state_q == ST_IDLE && !sync_cs) px_d = '0;
    else if (push && sync_dc && px_q != 16'hffff) px_d = px_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) px_q <= '0;
    else     px_q <= px_d;
  end

  assign px_count = px_q;
`endif

endmodule

// File: tb/tb_riscboy_lcd_spi_rx.sv
// Directed bench for riscboy_lcd_spi_rx; define RISCBOY_LCD_SPI_RX_PXCOUNT_EN to also exercise px_count.
module tb_riscboy_lcd_spi_rx;

  logic        clk = 1'b0;
  logic        rst, lcd_cs, lcd_dc, lcd_sck, lcd_mosi;
  logic [4:0]  cfg_width;
  logic        out_vld, out_rdy, out_dc, clr_flags, overflow, frame_err, busy;
  logic [15:0] out_data;
`ifdef RISCBOY_LCD_SPI_RX_PXCOUNT_EN
  logic [15:0] px_count;
`endif

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] beats [$];

  always #5 clk = ~clk;

  riscboy_lcd_spi_rx #(.W_DATA(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .lcd_cs(lcd_cs), .lcd_dc(lcd_dc), .lcd_sck(lcd_sck), .lcd_mosi(lcd_mosi),
    .cfg_width(cfg_width),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_dc(out_dc),
    .clr_flags(clr_flags), .overflow(overflow), .frame_err(frame_err), .busy(busy)
`ifdef RISCBOY_LCD_SPI_RX_PXCOUNT_EN
    , .px_count(px_count)
`endif
  );

  // Record every accepted beat as {dc, data}, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_vld && out_rdy) beats.push_back({15'd0, out_dc, out_data});
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    obs = (beats.size() != 0) ? beats.pop_front() : 32'hffff_ffff;
    check(tag, obs, exp);
  endtask

  task automatic send_bit(input logic b, input logic dc);
    lcd_mosi = b;
    lcd_dc   = dc;
    lcd_sck  = 1'b0;
    cycle(4);
    lcd_sck  = 1'b1;
    cycle(4);
  endtask

  task automatic send_word(input logic [15:0] w, input int n, input logic dc);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], dc);
  endtask

  task automatic end_frame();
    lcd_cs = 1'b1;
    cycle(6);
  endtask

  initial begin
    rst = 1'b1; lcd_cs = 1'b1; lcd_dc = 1'b0; lcd_sck = 1'b0; lcd_mosi = 1'b0;
    cfg_width = 5'd16; out_rdy = 1'b1; clr_flags = 1'b0;
    cycle(4);
    rst = 1'b0;
    cycle(2);
    @(negedge clk);
    check("rst_vld", {31'd0, out_vld}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_flags", {29'd0, overflow, frame_err, busy}, 32'd0);

    // Single 16-bit data word
    cycle(1);
    lcd_cs = 1'b0;
    cycle(4);
    send_word(16'hA5C3, 16, 1'b1);
    end_frame();
    check("t1_count", 32'(beats.size()), 32'd1);
    check_beat("t1_beat", {15'd0, 1'b1, 16'hA5C3});
    check("t1_flags", {30'd0, overflow, frame_err}, 32'd0);

    // Two back-to-back bytes, then busy timing after cs rises
    cfg_width = 5'd8;
    lcd_cs = 1'b0;
    cycle(4);
    send_word(16'h002A, 8, 1'b0);
    send_word(16'h003C, 8, 1'b0);
    lcd_cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t2_busy_hold", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t2_busy_drop", {31'd0, busy}, 32'd0);
    cycle(4);
    check("t2_count", 32'(beats.size()), 32'd2);
    check_beat("t2_beat0", {15'd0, 1'b0, 16'h002A});
    check_beat("t2_beat1", {15'd0, 1'b0, 16'h003C});

    // Overflow: five words into a stalled four-entry FIFO
    cfg_width = 5'd16;
    out_rdy = 1'b0;
    lcd_cs = 1'b0;
    cycle(4);
    send_word(16'h1111, 16, 1'b1);
    send_word(16'h2222, 16, 1'b0);
    send_word(16'h3333, 16, 1'b1);
    send_word(16'h4444, 16, 1'b0);
    send_word(16'h5555, 16, 1'b1);
    end_frame();
    @(negedge clk);
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    check("t3_head", {15'd0, out_vld, out_data}, {15'd0, 1'b1, 16'h1111});
    cycle(1);
    clr_flags = 1'b1;
    cycle(1);
    clr_flags = 1'b0;
    @(negedge clk);
    check("t3_ovf_clr", {31'd0, overflow}, 32'd0);
    cycle(1);
    out_rdy = 1'b1;
    cycle(8);
    check("t3_count", 32'(beats.size()), 32'd4);
    check_beat("t3_beat0", {15'd0, 1'b1, 16'h1111});
    check_beat("t3_beat1", {15'd0, 1'b0, 16'h2222});
    check_beat("t3_beat2", {15'd0, 1'b1, 16'h3333});
    check_beat("t3_beat3", {15'd0, 1'b0, 16'h4444});

    // Partial word aborted by cs, then a clean word
    lcd_cs = 1'b0;
    cycle(4);
    send_word(16'h001F, 5, 1'b1);
    end_frame();
    check("t4_nobeat", 32'(beats.size()), 32'd0);
    check("t4_ferr", {31'd0, frame_err}, 32'd1);
    lcd_cs = 1'b0;
    cycle(4);
    send_word(16'h1234, 16, 1'b1);
    end_frame();
    check_beat("t4_beat", {15'd0, 1'b1, 16'h1234});
    check("t4_ferr_sticky", {31'd0, frame_err}, 32'd1);
    clr_flags = 1'b1;
    cycle(1);
    clr_flags = 1'b0;
    @(negedge clk);
    check("t4_ferr_clr", {31'd0, frame_err}, 32'd0);

    // Width change mid-word applies only to the following word
    cycle(1);
    lcd_cs = 1'b0;
    cycle(4);
    send_word(16'h000B, 3, 1'b1);
    cfg_width = 5'd8;
    send_word(16'h1EEF, 13, 1'b1);
    send_word(16'h005A, 8, 1'b0);
    end_frame();
    check_beat("t5_wide", {15'd0, 1'b1, 16'h7EEF});
    check_beat("t5_narrow", {15'd0, 1'b0, 16'h005A});
    check("t5_ferr", {31'd0, frame_err}, 32'd0);

    // Out-of-range widths fall back to the full 16 bits
    cfg_width = 5'd0;
    lcd_cs = 1'b0;
    cycle(4);
    send_word(16'hC001, 16, 1'b1);
    cfg_width = 5'd20;
    send_word(16'h8E71, 16, 1'b0);
    end_frame();
    check_beat("t6_w0", {15'd0, 1'b1, 16'hC001});
    check_beat("t6_w20", {15'd0, 1'b0, 16'h8E71});

`ifdef RISCBOY_LCD_SPI_RX_PXCOUNT_EN
    cfg_width = 5'd8;
    lcd_cs = 1'b0;
    cycle(4);
    send_word(16'h002C, 8, 1'b0);
    send_word(16'h0011, 8, 1'b1);
    send_word(16'h0022, 8, 1'b1);
    send_word(16'h0033, 8, 1'b1);
    end_frame();
    check("px_three", {16'd0, px_count}, 32'd3);
    beats.delete();
    lcd_cs = 1'b0;
    cycle(6);
    check("px_reset", {16'd0, px_count}, 32'd0);
    end_frame();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/riscboy_lcd_spi_rx.md
Name: riscboy_lcd_spi_rx

Overview:
- Receive-side counterpart of the PPU LCD shifter.
- Oversamples the 4-wire LCD serial bus (cs, dc, sck, mosi) in a single fast clock domain and deserialises MSB-first words of programmable width.
- Pushes each completed word, tagged with its dc bit, into an internal FIFO with a valid/ready output stream.
- Used as a display-side capture/loopback endpoint for checking PPU output on-chip and in system benches.

Parameters:
- W_DATA, 16: maximum word width in bits. Data is right-justified in out_data.
- W_SHAMT, $clog2(W_DATA+1): width of cfg_width.
- FIFO_DEPTH, 4: output FIFO entries. Power of 2, ≥2.

Ports:
- clk  in  1  system clock. Must be ≥6× the sck frequency.
- rst  in  1  reset: synchronous, active-high.
- lcd_cs  in  1  async bus chip select, active low.
- lcd_dc  in  1  async bus data/command flag (1 = data).
- lcd_sck  in  1  async bus serial clock. Data is sampled on its rising edge.
- lcd_mosi  in  1  async bus serial data, MSB first.
- cfg_width  in  W_SHAMT  bits per word. 0 or >W_DATA is treated as W_DATA.
- out_vld  out  1  FIFO head valid.
- out_rdy  in  1  consumer ready. Pop happens when out_vld && out_rdy.
- out_data  out  W_DATA  word, right-justified, upper bits zero.
- out_dc  out  1  dc value captured with the word's last bit.
- clr_flags  in  1  one-cycle pulse that clears the sticky flags.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- frame_err  out  1  sticky: cs deasserted with a partial word pending.
- busy  out  1  synchronised cs is asserted (low) or bit count ≠ 0.

Behaviour:
- Synchronisation
  - All four bus inputs pass through 2-FF synchronisers, reset to cs=1, sck=0, dc=0, mosi=0.
  - sck_prev register holds the previous synchronised sck.
  - Rise event = sync_sck && !sck_prev && !sync_cs.
- Reset values
  - out_vld=0, out_data=0, out_dc=0, overflow=0, frame_err=0, busy=0.
  - Bit count=0, shift register=0, FIFO empty.
  - Reset mid-word discards the partial word and all FIFO contents.
- Receive FSM states
  - IDLE: cs high, bit count 0.
  - SHIFT: cs low.
- Transitions
  - IDLE→SHIFT when sync_cs falls.
  - SHIFT→IDLE when sync_cs rises. Bit count is cleared and the partial shift register is discarded.
  - If bit count ≠ 0 at that cs rise, set frame_err.
- Bit capture on a rise event
  - When bit count == 0, latch the effective width from cfg_width, so changes mid-word have no effect.
  - shift = {shift[W_DATA-2:0], sync_mosi}.
  - Increment bit count.
- Word completion
  - Occurs when the incremented count equals the latched width, in the same clock as the capture.
  - Word = next shift value masked to the latched width. dc = sync_dc.
  - Bit count returns to 0.
  - If the FIFO is not full: push the word.
  - If the FIFO is full: drop the word and set overflow.
- Push and pop in the same cycle
  - With the FIFO full and a pop in the same cycle, the push is accepted (pop-then-push) with no overflow.
  - With the FIFO empty, a pop is impossible (out_vld=0).
- Latency
  - A bus sck rise sampled at clk edge k causes the capture at edge k+2.
  - For the last bit, out_vld=1 after edge k+2 when the FIFO was empty.
- FIFO output
  - out_data/out_dc are the head entry. They are stable while out_vld && !out_rdy.
  - Pointer wrap uses an extra MSB bit: full when the MSBs differ and the remaining bits are equal.
- Sticky flags
  - Cleared by clr_flags.
  - If a set condition and clr_flags coincide, set wins.
- Back-to-back words: consecutive words within one cs-low frame are supported with no gap bits. dc may change between words.

Optional Feature:
- Macro: RISCBOY_LCD_SPI_RX_PXCOUNT_EN.
- When defined:
  - Adds output px_count [15:0].
  - Counts words pushed with dc=1 since the last falling edge of sync_cs, which resets it to 0.
  - Saturates at 16'hffff.
  - Dropped words are not counted.
- When undefined:
  - Port absent.
  - No counter logic.

Test Plan:
- cfg_width=16, cs low, shift 0xA5C3 MSB-first with dc=1, sck period 8 clk, out_rdy=1 → one beat out_data=0xA5C3, out_dc=1. overflow=0, frame_err=0.
- cfg_width=8, dc=0, bytes 0x2A then 0x3C in one frame, no gap → two beats 0x002A and 0x003C, both out_dc=0. busy drops 3 clk after cs rises.
- cfg_width=16, out_rdy=0, send FIFO_DEPTH+1=5 words → FIFO holds the first 4 and overflow=1. clr_flags → overflow=0. Drain → values match the first 4.
- Send 5 bits of a 16-bit word, then raise cs → no beat, frame_err=1. The next full word 0x1234 is received correctly.
- Change cfg_width from 16 to 8 after the 3rd bit of a word → the word still completes at 16 bits. The following word uses 8.
- With RISCBOY_LCD_SPI_RX_PXCOUNT_EN: frame of 1 command byte plus 3 data pixels → px_count=3. The next cs fall gives px_count=0.
